pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Drives the enable/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Resolves three hazards: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits.
- Sits beside the datapath. Reads control/address fields from the ID/EX and EX/MEM buffer outputs and the data-memory ready line. Keeps performance counters.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abandoning the access (>=2)
CNT_W, 32, width of stall/flush performance counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
i_ifid_rs  input  5  rs field of the instruction in IF/ID
i_ifid_rt  input  5  rt field of the instruction in IF/ID
i_ifid_uses_rt  input  1  IF/ID instruction reads rt as a source
i_idex_memToReg  input  1  ID/EX holds a load
i_idex_write_address  input  5  destination register of the ID/EX instruction
i_exmem_branch  input  1  EX/MEM holds a branch
i_exmem_zf  input  1  EX/MEM zero flag
i_exmem_memWrite  input  1  EX/MEM holds a store
i_exmem_memToReg  input  1  EX/MEM holds a load
i_dmem_ready  input  1  data memory completes the access this cycle
o_pc_en  output  1  PC update enable
o_pc_src  output  1  1 = load PC from EX/MEM branch address
o_ifid_en  output  1  IF/ID load enable
o_ifid_flush  output  1  IF/ID clear to NOP
o_idex_en  output  1  ID/EX load enable
o_idex_flush  output  1  ID/EX clear to bubble
o_exmem_en  output  1  EX/MEM load enable
o_exmem_flush  output  1  EX/MEM clear to bubble
o_memwb_flush  output  1  MEM/WB clear to bubble
o_dmem_req  output  1  data-memory access request
o_mem_error  output  1  sticky timeout flag
o_stall_cnt  output  CNT_W  cycles with o_pc_en=0 since reset, saturating
o_flush_cnt  output  CNT_W  taken-branch flush events since reset, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT. Registers: state, wait counter (clog2(MEM_TIMEOUT) bits), o_mem_error, o_stall_cnt, o_flush_cnt. All other outputs are combinational (Mealy) from state and inputs.
- Reset (rst_n=0 at posedge): state=RUN, wait counter=0, o_mem_error=0, both counters=0.
- While rst_n=0: all *_en=0, all *_flush=1, o_pc_src=0, o_dmem_req=0.
- memop = i_exmem_memWrite | i_exmem_memToReg. In RUN, o_dmem_req=memop. In MEM_WAIT, o_dmem_req=1.
- Decision order in RUN, first match wins:
  - (a) Memory wait: memop & !i_dmem_ready. Go to MEM_WAIT; all enables 0; o_memwb_flush=1; no flush of the other buffers; o_pc_src=0.
  - (b) Taken branch: i_exmem_branch & i_exmem_zf. o_pc_src=1; o_pc_en=1; flush IF/ID, ID/EX, EX/MEM in the same cycle; o_flush_cnt+1. Overrides a simultaneous load-use hazard.
  - (c) Load-use: i_idex_memToReg & i_idex_write_address!=0 & (i_idex_write_address==i_ifid_rs | (i_ifid_uses_rt & i_idex_write_address==i_ifid_rt)). o_pc_en=0; o_ifid_en=0; o_idex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble, because the forwarding unit covers MEM-to-EX.
  - (d) Otherwise: all enables 1, all flushes 0.
- MEM_WAIT:
  - Pipeline frozen: enables 0, o_memwb_flush=1. The wait counter increments each cycle.
  - On i_dmem_ready=1: state=RUN and the counter clears. The same cycle behaves as RUN with memop satisfied, so cases (b)-(d) are evaluated and MEM/WB captures.
  - If the counter reaches MEM_TIMEOUT-1 with ready still 0: set o_mem_error (sticky until reset), return to RUN, and the access is dropped (MEM/WB flushed that cycle). The pipeline advances on the next cycle.
- A branch sitting in EX/MEM during MEM_WAIT is not acted on until the wait ends.
- o_stall_cnt increments in every non-reset cycle with o_pc_en=0. Both counters saturate at all-ones.
- Reset mid-MEM_WAIT: returns to RUN with no error.

Decomposition:
- Shared package/header pipe_ctrl_defs holds the state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the register-zero constant 5'd0.
- One natural sub-module, load_use_detect: purely combinational comparison in case (c).
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all enables 0, flushes 1. After release, counters=0, o_mem_error=0, o_pc_en=1.
- Load-use: i_idex_memToReg=1, write_address=5'd8, i_ifid_rs=5'd8 -> one cycle with o_pc_en=0, o_ifid_en=0, o_idex_flush=1, then o_stall_cnt=1. Repeat with write_address=0 -> no stall.
- Branch: i_exmem_branch=1, zf=1, plus a load-use match -> o_pc_src=1, IF/ID, ID/EX and EX/MEM flush, no stall, o_flush_cnt=1. With zf=0 -> no action.
- Memory wait: i_exmem_memToReg=1, i_dmem_ready low for 3 cycles then high -> 3 frozen cycles with o_memwb_flush=1. Cycle 4 advances; o_stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, ready held 0 -> o_mem_error rises after 4 cycles in MEM_WAIT, FSM returns to RUN, pipeline advances next cycle, flag stays 1.
- Counter saturation: CNT_W=3, force 9 load-use stalls -> o_stall_cnt stops at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_defs
//   Shared definitions for the 5-stage pipeline hazard controller.
//   - state_e      : controller FSM states (RUN, MEM_WAIT)
//   - REG_ZERO     : architectural register $zero, never a real dependency
//   - pipe_ctrl_t  : bundle of all buffer enable/flush controls
//   - ctrl_*()     : canonical control bundles for advance/freeze/reset
// ---------------------------------------------------------------------------
package pipe_ctrl_defs;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic pc_src;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Every buffer loads, nothing is cleared.
    function automatic pipe_ctrl_t ctrl_advance();
        pipe_ctrl_t c;
        c.pc_en       = 1'b1;
        c.pc_src      = 1'b0;
        c.ifid_en     = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_en     = 1'b1;
        c.idex_flush  = 1'b0;
        c.exmem_en    = 1'b1;
        c.exmem_flush = 1'b0;
        c.memwb_flush = 1'b0;
        return c;
    endfunction

    // Whole pipeline held while data memory is busy; MEM/WB gets a bubble so
    // the stalled access is not written back more than once.
    function automatic pipe_ctrl_t ctrl_freeze();
        pipe_ctrl_t c;
        c.pc_en       = 1'b0;
        c.pc_src      = 1'b0;
        c.ifid_en     = 1'b0;
        c.ifid_flush  = 1'b0;
        c.idex_en     = 1'b0;
        c.idex_flush  = 1'b0;
        c.exmem_en    = 1'b0;
        c.exmem_flush = 1'b0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    // Held in reset: nothing loads, every buffer is cleared.
    function automatic pipe_ctrl_t ctrl_reset();
        pipe_ctrl_t c;
        c.pc_en       = 1'b0;
        c.pc_src      = 1'b0;
        c.ifid_en     = 1'b0;
        c.ifid_flush  = 1'b1;
        c.idex_en     = 1'b0;
        c.idex_flush  = 1'b1;
        c.exmem_en    = 1'b0;
        c.exmem_flush = 1'b1;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard check: the instruction in ID/EX is a load
//   whose destination is a source of the instruction in IF/ID.
//   Ports:
//     idex_mem_to_reg_i  : ID/EX holds a load
//     idex_wr_addr_i     : destination register of the ID/EX instruction
//     ifid_rs_i          : rs of the IF/ID instruction
//     ifid_rt_i          : rt of the IF/ID instruction
//     ifid_uses_rt_i     : IF/ID instruction reads rt
//     hazard_o           : one bubble is required
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_defs::*;
(
    input  logic       idex_mem_to_reg_i,
    input  logic [4:0] idex_wr_addr_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       ifid_uses_rt_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_wr_addr_i == ifid_rs_i);
    // rt only matters when the consumer actually reads it (not for I-type
    // instructions that write rt).
    assign rt_match = ifid_uses_rt_i && (idex_wr_addr_i == ifid_rt_i);

    // Writes to $zero are discarded, so they never create a dependency.
    assign hazard_o = idex_mem_to_reg_i
                   && (idex_wr_addr_i != REG_ZERO)
                   && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencer for the 5-stage MIPS pipeline. Produces the enable and
//   flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, resolving
//   load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
//   Also keeps saturating stall/flush performance counters.
//
//   Parameters:
//     MEM_TIMEOUT : max cycles spent in MEM_WAIT before the access is dropped
//     CNT_W       : width of the performance counters
//   Ports:
//     clk, rst_n                 : clock, synchronous active-low reset
//     i_ifid_*                   : source fields of the IF/ID instruction
//     i_idex_*                   : load flag / destination of ID/EX
//     i_exmem_*                  : branch/zero/store/load flags of EX/MEM
//     i_dmem_ready               : data memory completes this cycle
//     o_pc_en, o_pc_src          : PC enable / select branch target
//     o_*_en, o_*_flush          : pipeline buffer load / clear controls
//     o_dmem_req                 : data memory request
//     o_mem_error                : sticky memory timeout flag
//     o_stall_cnt, o_flush_cnt   : saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_ifid_rs,
    input  logic [4:0]       i_ifid_rt,
    input  logic             i_ifid_uses_rt,
    input  logic             i_idex_memToReg,
    input  logic [4:0]       i_idex_write_address,
    input  logic             i_exmem_branch,
    input  logic             i_exmem_zf,
    input  logic             i_exmem_memWrite,
    input  logic             i_exmem_memToReg,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_pc_src,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_exmem_flush,
    output logic             o_memwb_flush,
    output logic             o_dmem_req,
    output logic             o_mem_error,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int                WCNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    pipe_ctrl_t ctrl;
    logic       dmem_req;
    logic       flush_evt;
    logic       eval_hazards;
    logic       memop;
    logic       branch_taken;
    logic       load_use;

    assign memop        = i_exmem_memWrite | i_exmem_memToReg;
    assign branch_taken = i_exmem_branch & i_exmem_zf;

    load_use_detect u_load_use_detect (
        .idex_mem_to_reg_i (i_idex_memToReg),
        .idex_wr_addr_i    (i_idex_write_address),
        .ifid_rs_i         (i_ifid_rs),
        .ifid_rt_i         (i_ifid_rt),
        .ifid_uses_rt_i    (i_ifid_uses_rt),
        .hazard_o          (load_use)
    );

    // -----------------------------------------------------------------------
    // Next state and Mealy controls
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl         = ctrl_advance();
        dmem_req     = 1'b0;
        eval_hazards = 1'b0;
        flush_evt    = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_error_d  = mem_error_q;
        drop_d       = 1'b0;

        case (state_q)
            RUN: begin
                dmem_req = memop;
                // drop_q marks the cycle after a timeout: the abandoned access
                // is still in EX/MEM and must not re-trigger a wait.
                if (memop && !i_dmem_ready && !drop_q) begin
                    ctrl       = ctrl_freeze();
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    eval_hazards = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (i_dmem_ready) begin
                    // Completion cycle behaves like RUN with memory satisfied.
                    state_d      = RUN;
                    wait_cnt_d   = '0;
                    eval_hazards = 1'b1;
                end else if (wait_cnt_q == WCNT_LAST) begin
                    ctrl        = ctrl_freeze();
                    state_d     = RUN;
                    wait_cnt_d  = '0;
                    mem_error_d = 1'b1;
                    drop_d      = 1'b1;
                end else begin
                    ctrl       = ctrl_freeze();
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (eval_hazards) begin
            if (branch_taken) begin
                // A taken branch squashes everything younger, including any
                // instruction that a load-use stall would have held.
                ctrl.pc_src      = 1'b1;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.exmem_flush = 1'b1;
                flush_evt        = 1'b1;
            end else if (load_use) begin
                // Single bubble: MEM-to-EX forwarding covers the rest.
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_en    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
        end

        if (!rst_n) begin
            ctrl      = ctrl_reset();
            dmem_req  = 1'b0;
            flush_evt = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_evt && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            drop_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            drop_q      <= drop_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_pc_en       = ctrl.pc_en;
    assign o_pc_src      = ctrl.pc_src;
    assign o_ifid_en     = ctrl.ifid_en;
    assign o_ifid_flush  = ctrl.ifid_flush;
    assign o_idex_en     = ctrl.idex_en;
    assign o_idex_flush  = ctrl.idex_flush;
    assign o_exmem_en    = ctrl.exmem_en;
    assign o_exmem_flush = ctrl.exmem_flush;
    assign o_memwb_flush = ctrl.memwb_flush;
    assign o_dmem_req    = dmem_req;
    assign o_mem_error   = mem_error_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule
